// File: rtl/accum_fsmd.sv
// Accumulator FSMD: control FSM plus W-bit add/subtract datapath with iteration limit and sticky overflow.
// Define ACCUM_SAT_EN for saturating arithmetic; default build wraps modulo 2^W.
module accum_fsmd #(
    parameter int W        = 8,
    parameter int CW       = 4,
    parameter int MAX_ITER = 15
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  inputA,
    input  logic          inputB,
    input  logic          inputC,
    input  logic          sub,
    output logic [W-1:0]  value,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_CHECKC = 2'd1,
        S_CHECKB = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam logic [CW-1:0] LIMIT = CW'(MAX_ITER);

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_value;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [W:0]    w_res;
    logic [W-1:0]  w_value_nxt;
    logic          w_start_run;
    logic          w_acc;

    // Bit W of the widened result is the carry (add) or borrow (sub).
    always_comb begin
        w_res = '0;
        if (sub)
            w_res = {1'b0, r_value} - {1'b0, inputA};
        else
            w_res = {1'b0, r_value} + {1'b0, inputA};
    end

    always_comb begin
        w_value_nxt = w_res[W-1:0];
`ifdef ACCUM_SAT_EN
        if (w_res[W])
            w_value_nxt = sub ? {W{1'b0}} : {W{1'b1}};
`endif
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   if (start) w_next = S_CHECKC;
            S_CHECKC: w_next = (inputC && (r_count < LIMIT)) ? S_CHECKB : S_STOP;
            S_CHECKB: w_next = S_CHECKC;
            S_STOP:   if (start) w_next = S_CHECKC;
            default:  w_next = S_INIT;
        endcase
    end

    assign w_start_run = start && ((r_state == S_INIT) || (r_state == S_STOP));
    assign w_acc       = inputB && (r_state == S_CHECKB);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_INIT;
            r_value <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_run) begin
                r_value <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else if (w_acc) begin
                r_value <= w_value_nxt;
                r_count <= r_count + 1'b1;
                r_ovf   <= r_ovf | w_res[W];
            end
        end
    end

    assign value    = r_value;
    assign count    = r_count;
    assign overflow = r_ovf;
    assign busy     = (r_state == S_CHECKC) || (r_state == S_CHECKB);
    assign done     = (r_state == S_STOP);

endmodule
